bank_sram_port_arb: RTL and testbench
=====================================

Name: bank_sram_port_arb

Overview:
- Shares the single bank SRAM-controller command port between two requesters:
  - the issue queue, which sends single-beat read/write/linefill/writeback commands;
  - the refill writer, which sends two-beat 256-bit linefill writes from BIU return data.
- Round-robin arbitration with an urgency override. Refill lines are atomic (two consecutive beats). Output is registered. Sits between the ISU issue queue / BIU refill path and the SRAM controller.

Parameters:
- CNT_WIDTH, 16, width of the saturating per-source grant statistics counters.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- iq_valid_i  in  1  issue-queue command valid
- iq_ready_o  out  1  issue-queue command accepted this cycle
- iq_opcode_i  in  3  0 write, 1 read, 2 read+linefill, 3 writeback; bit2 always 0
- iq_set_way_offset_i  in  7  {set,way,offset} SRAM address
- iq_wbuffer_id_i  in  8  write-buffer id
- iq_rob_id_i  in  3  xbar ROB number
- iq_ch_id_i  in  2  channel id
- rf_valid_i  in  1  refill line valid
- rf_ready_o  out  1  refill line accepted (whole 256-bit line captured)
- rf_set_way_i  in  6  {set,way} line address
- rf_data_i  in  256  line data; [127:0] offset0, [255:128] offset1
- rf_urgent_i  in  1  refill buffer near full; refill takes priority
- sram_valid_o  out  1  command valid to SRAM controller
- sram_ready_i  in  1  SRAM controller accepts
- sram_opcode_o  out  3  IQ opcode passthrough, or 3'b100 for refill write
- sram_addr_o  out  7  SRAM address
- sram_wdata_o  out  128  refill beat data; 0 for IQ commands
- sram_wbuffer_id_o  out  8  passthrough; 0 for refill
- sram_rob_id_o  out  3  passthrough; 0 for refill
- sram_ch_id_o  out  2  passthrough; 0 for refill
- busy_o  out  1  state != IDLE
- iq_grant_cnt_o  out  CNT_WIDTH  IQ grants, saturating
- rf_grant_cnt_o  out  CNT_WIDTH  refill grants, saturating

Behaviour:
- States:
  - IDLE: output register empty.
  - IQ_HOLD: one IQ command held in the output register.
  - RF_BEAT0: refill offset0 beat held.
  - RF_BEAT1: refill offset1 beat held.
- Reset (rst_ni low, asynchronous):
  - state=IDLE; all outputs 0 (sram_valid_o, sram_* fields, ready outputs, busy_o, counters).
  - last_grant=REFILL, so the IQ wins the first tie.
  - Any in-flight command is dropped; the whole bank resets together.
- Accept slot (acc) is true when:
  - state==IDLE, or
  - state==IQ_HOLD and sram_ready_i, or
  - state==RF_BEAT1 and sram_ready_i.
  - There is never an accept slot in RF_BEAT0.
- Arbitration, only when acc:
  - only one source valid: that source wins;
  - both valid and rf_urgent_i: refill wins;
  - both valid, not urgent: the source != last_grant wins.
- Grant effects:
  - iq_ready_o and rf_ready_o are combinational and are 1 only for the winner in an acc cycle. They never assert together. Each requester must hold its valid and fields until its ready.
  - IQ grant: next cycle sram_valid_o=1, fields are registered copies of the IQ inputs, state=IQ_HOLD, last_grant=IQ.
  - Refill grant: rf_data_i[255:128] and rf_set_way_i are captured into a line register. Next cycle: sram_addr_o={rf_set_way_i,1'b0}, sram_wdata_o=rf_data_i[127:0], opcode 3'b100, state=RF_BEAT0, last_grant=REFILL.
- RF_BEAT0 with sram_ready_i: next cycle addr={set_way,1'b1}, wdata=captured [255:128], state=RF_BEAT1. The two beats are always back-to-back at the output and are never interleaved with IQ commands.
- Return to idle:
  - Handshake in IQ_HOLD or RF_BEAT1 with no winner: state=IDLE, sram_valid_o=0 next cycle.
  - Handshake with a winner: load the new command directly, giving 1 command per cycle throughput.
- Backpressure: while sram_valid_o=1 and sram_ready_i=0, all sram_* outputs hold stable and no grant occurs.
- Latency: grant cycle N gives sram_valid_o in cycle N+1.
- Counters:
  - Increment by 1 on each grant of their source; a refill line counts once.
  - Saturate at all-ones and never wrap.
- busy_o=1 whenever state != IDLE.

Test Plan:
- Reset, then IQ valid with opcode=1, addr=7'h25, wbuf=8'h3C, rob=5, ch=2 -> iq_ready_o=1 in cycle 0; cycle 1 sram_valid_o=1 with identical fields, wdata=0; sram_ready_i=1 then returns to IDLE; iq_grant_cnt_o=1.
- Refill set_way=6'h12, data={128'hB..B,128'hA..A}, SRAM always ready -> rf_ready_o one cycle; beats addr 7'h24 wdata A..A, then addr 7'h25 wdata B..B, opcode 3'b100 both, consecutive cycles; rf_grant_cnt_o=1.
- Both valid continuously, rf_urgent_i=0, SRAM always ready -> grants alternate IQ, RF(2 beats), IQ, RF. First grant is IQ, and there is no IQ beat between the two refill beats.
- Both valid, rf_urgent_i=1 -> refill wins every slot; the IQ is starved while urgent; deassert urgent -> IQ granted at the next slot.
- Hold sram_ready_i=0 for 5 cycles in RF_BEAT0 -> addr and wdata stable, iq_ready_o=0 throughout; release -> beat1 follows the next cycle.
- Drive rst_ni low mid-RF_BEAT1 -> sram_valid_o, busy_o and counters go to 0 immediately; after release, IQ wins a simultaneous tie. Force a counter to all-ones (CNT_WIDTH=2, 4 grants) -> it stays at 3.

Source files
------------

// File: rtl/bank_sram_port_arb_if.sv
// Command-port bundle between the issue queue / refill writer and the SRAM controller.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface bank_sram_port_arb_if;
    logic         iq_valid_i;
    logic         iq_ready_o;
    logic [2:0]   iq_opcode_i;
    logic [6:0]   iq_set_way_offset_i;
    logic [7:0]   iq_wbuffer_id_i;
    logic [2:0]   iq_rob_id_i;
    logic [1:0]   iq_ch_id_i;
    logic         rf_valid_i;
    logic         rf_ready_o;
    logic [5:0]   rf_set_way_i;
    logic [255:0] rf_data_i;
    logic         rf_urgent_i;
    logic         sram_valid_o;
    logic         sram_ready_i;
    logic [2:0]   sram_opcode_o;
    logic [6:0]   sram_addr_o;
    logic [127:0] sram_wdata_o;
    logic [7:0]   sram_wbuffer_id_o;
    logic [2:0]   sram_rob_id_o;
    logic [1:0]   sram_ch_id_o;

    modport slave (
        input  iq_valid_i, iq_opcode_i, iq_set_way_offset_i, iq_wbuffer_id_i, iq_rob_id_i, iq_ch_id_i,
        input  rf_valid_i, rf_set_way_i, rf_data_i, rf_urgent_i, sram_ready_i,
        output iq_ready_o, rf_ready_o,
        output sram_valid_o, sram_opcode_o, sram_addr_o, sram_wdata_o,
        output sram_wbuffer_id_o, sram_rob_id_o, sram_ch_id_o
    );

    modport master (
        output iq_valid_i, iq_opcode_i, iq_set_way_offset_i, iq_wbuffer_id_i, iq_rob_id_i, iq_ch_id_i,
        output rf_valid_i, rf_set_way_i, rf_data_i, rf_urgent_i, sram_ready_i,
        input  iq_ready_o, rf_ready_o,
        input  sram_valid_o, sram_opcode_o, sram_addr_o, sram_wdata_o,
        input  sram_wbuffer_id_o, sram_rob_id_o, sram_ch_id_o
    );
endinterface

// File: rtl/bank_sram_port_arb.sv
// Round-robin arbiter (with refill urgency override) sharing the bank SRAM command port
// between the issue queue and the two-beat refill writer; output is registered.
module bank_sram_port_arb #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    bank_sram_port_arb_if.slave  bus,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] iq_grant_cnt_o,
    output logic [CNT_WIDTH-1:0] rf_grant_cnt_o
);

    typedef enum logic [1:0] {IDLE, IQ_HOLD, RF_BEAT0, RF_BEAT1} state_t;
    typedef enum logic {SRC_IQ, SRC_RF} src_t;

    state_t         state;
    src_t           last_grant;
    logic           valid_q;
    logic [2:0]     opcode_q;
    logic [6:0]     addr_q;
    logic [127:0]   wdata_q;
    logic [7:0]     wbuf_q;
    logic [2:0]     rob_q;
    logic [1:0]     ch_q;
    logic [5:0]     line_sw_q;
    logic [127:0]   line_hi_q;
    logic [CNT_WIDTH-1:0] iq_cnt_q;
    logic [CNT_WIDTH-1:0] rf_cnt_q;

    logic acc;
    logic iq_win;
    logic rf_win;

    always_comb begin
        acc = (state == IDLE) ||
              (((state == IQ_HOLD) || (state == RF_BEAT1)) && bus.sram_ready_i);
        iq_win = acc && bus.iq_valid_i &&
                 (!bus.rf_valid_i || (!bus.rf_urgent_i && (last_grant == SRC_RF)));
        rf_win = acc && bus.rf_valid_i && !iq_win;
    end

    // Readies are gated by reset so nothing is accepted while the bank is held in reset.
    assign bus.iq_ready_o        = iq_win && rst_ni;
    assign bus.rf_ready_o        = rf_win && rst_ni;
    assign bus.sram_valid_o      = valid_q;
    assign bus.sram_opcode_o     = opcode_q;
    assign bus.sram_addr_o       = addr_q;
    assign bus.sram_wdata_o      = wdata_q;
    assign bus.sram_wbuffer_id_o = wbuf_q;
    assign bus.sram_rob_id_o     = rob_q;
    assign bus.sram_ch_id_o      = ch_q;
    assign busy_o                = (state != IDLE);
    assign iq_grant_cnt_o        = iq_cnt_q;
    assign rf_grant_cnt_o        = rf_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            last_grant <= SRC_RF;
            valid_q    <= 1'b0;
            opcode_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wbuf_q     <= '0;
            rob_q      <= '0;
            ch_q       <= '0;
            line_sw_q  <= '0;
            line_hi_q  <= '0;
            iq_cnt_q   <= '0;
            rf_cnt_q   <= '0;
        end else if (iq_win) begin
            state      <= IQ_HOLD;
            last_grant <= SRC_IQ;
            valid_q    <= 1'b1;
            opcode_q   <= bus.iq_opcode_i;
            addr_q     <= bus.iq_set_way_offset_i;
            wdata_q    <= '0;
            wbuf_q     <= bus.iq_wbuffer_id_i;
            rob_q      <= bus.iq_rob_id_i;
            ch_q       <= bus.iq_ch_id_i;
            if (iq_cnt_q != '1)
                iq_cnt_q <= iq_cnt_q + CNT_WIDTH'(1);
        end else if (rf_win) begin
            // Upper half waits in the line register so beat1 can follow without re-asking the writer.
            state      <= RF_BEAT0;
            last_grant <= SRC_RF;
            valid_q    <= 1'b1;
            opcode_q   <= 3'b100;
            addr_q     <= {bus.rf_set_way_i, 1'b0};
            wdata_q    <= bus.rf_data_i[127:0];
            wbuf_q     <= '0;
            rob_q      <= '0;
            ch_q       <= '0;
            line_sw_q  <= bus.rf_set_way_i;
            line_hi_q  <= bus.rf_data_i[255:128];
            if (rf_cnt_q != '1)
                rf_cnt_q <= rf_cnt_q + CNT_WIDTH'(1);
        end else begin
            case (state)
                RF_BEAT0: begin
                    if (bus.sram_ready_i) begin
                        state   <= RF_BEAT1;
                        addr_q  <= {line_sw_q, 1'b1};
                        wdata_q <= line_hi_q;
                    end
                end
                IQ_HOLD, RF_BEAT1: begin
                    if (bus.sram_ready_i) begin
                        state   <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bank_sram_port_arb.sv
// Randomized scoreboard bench: a transaction-level model predicts grants and queues the
// expected SRAM beats; an independent monitor pops and compares them on every handshake.
module tb_bank_sram_port_arb;

    localparam int unsigned CW  = 3;
    localparam int          MAX = (1 << CW) - 1;

    typedef struct packed {
        logic [2:0]   op;
        logic [6:0]   addr;
        logic [127:0] wdata;
        logic [7:0]   wb;
        logic [2:0]   rob;
        logic [1:0]   ch;
    } beat_t;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          busy_o;
    logic [CW-1:0] iq_grant_cnt_o;
    logic [CW-1:0] rf_grant_cnt_o;

    bank_sram_port_arb_if bus();

    bank_sram_port_arb #(.CNT_WIDTH(CW)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .bus            (bus),
        .busy_o         (busy_o),
        .iq_grant_cnt_o (iq_grant_cnt_o),
        .rf_grant_cnt_o (rf_grant_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int errors  = 0;

    beat_t exp_q[$];

    // reference model state
    int   pend;
    bit   last_was_iq;
    int   iq_n, rf_n;
    bit   iq_act, rf_act;
    beat_t       iq_req;
    logic [5:0]  rf_sw;
    logic [255:0] rf_dat;

    function automatic int sat(input int n);
        return (n > MAX) ? MAX : n;
    endfunction

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // monitor: compares presented beats against the scoreboard
    always @(negedge clk_i) begin
        if (rst_ni) begin
            check("sram_valid", 256'(bus.sram_valid_o), 256'(exp_q.size() > 0));
            check("busy", 256'(busy_o), 256'(exp_q.size() > 0));
            if (bus.sram_valid_o && bus.sram_ready_i) begin
                beat_t got;
                got = {bus.sram_opcode_o, bus.sram_addr_o, bus.sram_wdata_o,
                       bus.sram_wbuffer_id_o, bus.sram_rob_id_o, bus.sram_ch_id_o};
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 256'(got), 256'(0));
                end else begin
                    check("beat", 256'(got), 256'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic model_reset();
        exp_q.delete();
        pend = 0; last_was_iq = 1'b0; iq_n = 0; rf_n = 0;
        iq_act = 1'b0; rf_act = 1'b0;
    endtask

    task automatic new_iq();
        iq_req.op    = 3'($urandom_range(3));
        iq_req.addr  = 7'($urandom);
        iq_req.wdata = '0;
        iq_req.wb    = 8'($urandom);
        iq_req.rob   = 3'($urandom);
        iq_req.ch    = 2'($urandom);
        iq_act = 1'b1;
    endtask

    task automatic new_rf();
        rf_sw = 6'($urandom);
        for (int i = 0; i < 8; i++) rf_dat[i*32 +: 32] = $urandom;
        rf_act = 1'b1;
    endtask

    task automatic step(input int p_iq, input int p_rf, input int p_urg, input int p_rdy);
        bit acc, w_iq, w_rf, rdy, urg;
        beat_t b;
        @(posedge clk_i); #1;
        if (!iq_act && $urandom_range(99) < p_iq) new_iq();
        if (!rf_act && $urandom_range(99) < p_rf) new_rf();
        urg = ($urandom_range(99) < p_urg);
        rdy = ($urandom_range(99) < p_rdy);
        bus.iq_valid_i          = iq_act;
        bus.iq_opcode_i         = iq_req.op;
        bus.iq_set_way_offset_i = iq_req.addr;
        bus.iq_wbuffer_id_i     = iq_req.wb;
        bus.iq_rob_id_i         = iq_req.rob;
        bus.iq_ch_id_i          = iq_req.ch;
        bus.rf_valid_i          = rf_act;
        bus.rf_set_way_i        = rf_sw;
        bus.rf_data_i           = rf_dat;
        bus.rf_urgent_i         = urg;
        bus.sram_ready_i        = rdy;
        @(negedge clk_i); #1;
        // a new command may enter only if the output stage will be empty after this cycle
        acc  = (pend == 0) || (pend == 1 && rdy);
        w_iq = acc && iq_act && (!rf_act || (!urg && !last_was_iq));
        w_rf = acc && rf_act && !w_iq;
        check("readies", 256'({bus.iq_ready_o, bus.rf_ready_o}), 256'({w_iq, w_rf}));
        check("iq_cnt", 256'(iq_grant_cnt_o), 256'(sat(iq_n)));
        check("rf_cnt", 256'(rf_grant_cnt_o), 256'(sat(rf_n)));
        if (pend > 0 && rdy) pend--;
        if (w_iq) begin
            exp_q.push_back(iq_req);
            pend++; last_was_iq = 1'b1; iq_n++; iq_act = 1'b0;
        end
        if (w_rf) begin
            b = '{op: 3'b100, addr: {rf_sw, 1'b0}, wdata: rf_dat[127:0], wb: '0, rob: '0, ch: '0};
            exp_q.push_back(b);
            b.addr  = {rf_sw, 1'b1};
            b.wdata = rf_dat[255:128];
            exp_q.push_back(b);
            pend += 2; last_was_iq = 1'b0; rf_n++; rf_act = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk_i); #3;
        rst_ni = 1'b0;
        #1;
        check("rst_valid", 256'(bus.sram_valid_o), 256'(0));
        check("rst_busy", 256'(busy_o), 256'(0));
        check("rst_cnts", 256'({iq_grant_cnt_o, rf_grant_cnt_o}), 256'(0));
        check("rst_readies", 256'({bus.iq_ready_o, bus.rf_ready_o}), 256'(0));
        model_reset();
        bus.iq_valid_i = 1'b0;
        bus.rf_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #2 rst_ni = 1'b1;
    endtask

    initial begin
        model_reset();
        iq_req = '0; rf_sw = '0; rf_dat = '0;
        bus.iq_valid_i = 1'b1; bus.rf_valid_i = 1'b1; bus.rf_urgent_i = 1'b0;
        bus.sram_ready_i = 1'b0;
        bus.iq_opcode_i = '0; bus.iq_set_way_offset_i = '0; bus.iq_wbuffer_id_i = '0;
        bus.iq_rob_id_i = '0; bus.iq_ch_id_i = '0; bus.rf_set_way_i = '0; bus.rf_data_i = '0;
        #2;
        check("init_valid", 256'(bus.sram_valid_o), 256'(0));
        check("init_readies", 256'({bus.iq_ready_o, bus.rf_ready_o}), 256'(0));
        check("init_cnts", 256'({busy_o, iq_grant_cnt_o, rf_grant_cnt_o}), 256'(0));
        bus.iq_valid_i = 1'b0; bus.rf_valid_i = 1'b0;
        #10 rst_ni = 1'b1;

        // directed single IQ command, then a single refill line
        iq_req = '{op: 3'd1, addr: 7'h25, wdata: '0, wb: 8'h3C, rob: 3'd5, ch: 2'd2};
        iq_act = 1'b1;
        repeat (4) step(0, 0, 0, 100);
        rf_sw = 6'h12; rf_dat = {{32{4'hB}}, {32{4'hA}}}; rf_act = 1'b1;
        repeat (5) step(0, 0, 0, 100);
        // tie after reset goes to IQ, then strict alternation
        do_reset();
        repeat (40) step(100, 100, 0, 100);
        // urgent refill starves the IQ, then releases it
        repeat (30) step(100, 100, 100, 100);
        repeat (10) step(100, 100, 0, 100);
        // heavy backpressure
        repeat (150) step(80, 60, 20, 25);
        // mixed random traffic with mid-run resets
        for (int r = 0; r < 4; r++) begin
            repeat (200) step(60, 40, 15, 70);
            do_reset();
        end
        repeat (100) step(50, 50, 30, 50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
